// File: rtl/basic_gates.sv
// Registered bank of the eight basic logic functions applied bitwise to a and b.
// Results load together on an in_valid edge and are held otherwise; out_valid flags a fresh capture.
module basic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] ya,
  output logic [WIDTH-1:0] yna,
  output logic [WIDTH-1:0] yo,
  output logic [WIDTH-1:0] yno,
  output logic [WIDTH-1:0] yx,
  output logic [WIDTH-1:0] yxn,
  output logic [WIDTH-1:0] ynota,
  output logic [WIDTH-1:0] ynotb
);

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] or_s;
  logic [WIDTH-1:0] xor_s;

  logic             valid_r;
  logic [WIDTH-1:0] ya_r;
  logic [WIDTH-1:0] yna_r;
  logic [WIDTH-1:0] yo_r;
  logic [WIDTH-1:0] yno_r;
  logic [WIDTH-1:0] yx_r;
  logic [WIDTH-1:0] yxn_r;
  logic [WIDTH-1:0] ynota_r;
  logic [WIDTH-1:0] ynotb_r;

  // Shared base terms; the inverting results are derived from these at capture.
  always_comb begin
    and_s = a & b;
    or_s  = a | b;
    xor_s = a ^ b;
  end

  // Result registers: reset to all-zeros (inverting outputs included), load on in_valid, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      ya_r    <= {WIDTH{1'b0}};
      yna_r   <= {WIDTH{1'b0}};
      yo_r    <= {WIDTH{1'b0}};
      yno_r   <= {WIDTH{1'b0}};
      yx_r    <= {WIDTH{1'b0}};
      yxn_r   <= {WIDTH{1'b0}};
      ynota_r <= {WIDTH{1'b0}};
      ynotb_r <= {WIDTH{1'b0}};
    end else if (in_valid) begin
      valid_r <= 1'b1;
      ya_r    <= and_s;
      yna_r   <= ~and_s;
      yo_r    <= or_s;
      yno_r   <= ~or_s;
      yx_r    <= xor_s;
      yxn_r   <= ~xor_s;
      ynota_r <= ~a;
      ynotb_r <= ~b;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign ya        = ya_r;
  assign yna       = yna_r;
  assign yo        = yo_r;
  assign yno       = yno_r;
  assign yx        = yx_r;
  assign yxn       = yxn_r;
  assign ynota     = ynota_r;
  assign ynotb     = ynotb_r;

endmodule

// File: tb/tb_basic_gates.sv
// Scoreboard bench for basic_gates: a WIDTH=8 and a WIDTH=1 instance share stimulus and are
// checked against a truth-table reference model through an expected-result queue.
module tb_basic_gates;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;

  logic       v8;
  logic [7:0] ya8, yna8, yo8, yno8, yx8, yxn8, ynota8, ynotb8;
  logic       v1;
  logic       ya1, yna1, yo1, yno1, yx1, yxn1, ynota1, ynotb1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  basic_gates #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(v8), .ya(ya8), .yna(yna8), .yo(yo8), .yno(yno8),
    .yx(yx8), .yxn(yxn8), .ynota(ynota8), .ynotb(ynotb8)
  );

  basic_gates #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0]), .b(b[0]),
    .out_valid(v1), .ya(ya1), .yna(yna1), .yo(yo1), .yno(yno1),
    .yx(yx1), .yxn(yxn1), .ynota(ynota1), .ynotb(ynotb1)
  );

  // Truth tables indexed by {a_bit, b_bit}: ya, yna, yo, yno, yx, yxn, ynota, ynotb
  localparam logic [3:0] TT [0:7] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001,
                                      4'b0110, 4'b1001, 4'b0011, 4'b0101};

  typedef struct packed {
    logic            v;
    logic [7:0][7:0] y;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and push the state the outputs must show after the next edge.
  task automatic step(input logic r, input logic iv, input logic [7:0] av, input logic [7:0] bv);
    rst = r; in_valid = iv; a = av; b = bv;
    if (r) begin
      model.v = 1'b0;
      model.y = '0;
    end else if (iv) begin
      model.v = 1'b1;
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < 8; i++)
          model.y[k][i] = TT[k][{av[i], bv[i]}];
    end else begin
      model.v = 1'b0;
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
  endtask

  logic [7:0][7:0] act8;
  logic [7:0]      act1;
  string           fname [0:7] = '{"ya", "yna", "yo", "yno", "yx", "yxn", "ynota", "ynotb"};

  always_comb begin
    act8 = {ynotb8, ynota8, yxn8, yx8, yno8, yo8, yna8, ya8};
    act1 = {ynotb1, ynota1, yxn1, yx1, yno1, yo1, yna1, ya1};
  end

  // Monitor: once per cycle, away from the active edge, compare both instances against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("out_valid_w8", {63'd0, v8}, {63'd0, e.v});
      chk("out_valid_w1", {63'd0, v1}, {63'd0, e.v});
      for (int k = 0; k < 8; k++) begin
        chk({fname[k], "_w8"}, {56'd0, act8[k]}, {56'd0, e.y[k]});
        chk({fname[k], "_w1"}, {63'd0, act1[k]}, {63'd0, e.y[k][0]});
      end
    end
  end

  initial begin
    // Reset held two cycles with live operands
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    // Truth table on bit 0, back-to-back
    step(1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'h01, 8'h01);
    // Hold: capture (1,0) then drop in_valid while toggling operands
    step(1'b0, 1'b1, 8'h01, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h01);
    step(1'b0, 1'b0, 8'hFF, 8'hFF);
    step(1'b0, 1'b0, 8'h5A, 8'hA5);
    // Bitwise pattern
    step(1'b0, 1'b1, 8'hF0, 8'hCC);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // Reset mid-stream, then normal capture
    step(1'b0, 1'b1, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    // Random traffic with occasional reset
    for (int n = 0; n < 1000; n++) begin
      step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           8'($urandom), 8'($urandom));
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/basic_gates.md
Name: basic_gates

Overview:
- Registered bank of the eight basic two-input/one-input logic functions (AND, NAND, OR, NOR, XOR, XNOR, NOT a, NOT b) applied bitwise to operands a and b.
- Used as a small logic primitive and reference block for gate-level checks.
- All results are captured in flops on one clock, with a valid flag tracking them.

Parameters:
- WIDTH, 1, bit width of operands a, b and of every result output; bitwise operation, legal range 1..64.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands a/b are valid this cycle and are to be captured
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result outputs hold a freshly computed result
- ya  output  WIDTH  a AND b
- yna  output  WIDTH  NOT(a AND b)
- yo  output  WIDTH  a OR b
- yno  output  WIDTH  NOT(a OR b)
- yx  output  WIDTH  a XOR b
- yxn  output  WIDTH  NOT(a XOR b)
- ynota  output  WIDTH  NOT a
- ynotb  output  WIDTH  NOT b

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: rst sampled high on a rising clk edge resets the block; no asynchronous path.
- Reset values: all eight result outputs are all-zeros, including the inverting outputs, and out_valid = 0. Reset overrides in_valid in the same cycle.
- Capture: on a rising edge with rst = 0 and in_valid = 1, every result register loads its function of the current a, b.
  - Each bit i of a result depends only on bit i of a and b.
  - Latency is exactly 1 cycle from the input edge to the registered output.
- out_valid timing: out_valid is set to 1 on the same edge as a capture, and is 0 on any edge where in_valid = 0.
- Hold: when in_valid = 0, result outputs keep their last captured values. They are not cleared and not recomputed.
- Per-capture identities, bitwise:
  - yna = ~ya, yno = ~yo, yxn = ~yx
  - ynota = ~a, ynotb = ~b
  - ya = ~(ynota | ynotb)
  - These identities do not hold in the reset state (all zeros); this is intentional.
- Back-to-back captures: a new result every cycle is supported; no throughput limit and no backpressure.
- Reset mid-stream: a reset asserted between captures clears outputs on that edge. The first capture after rst deasserts behaves normally.
- No X propagation from the flops after reset. Outputs must never be undriven.
- The block is fully synchronous; no combinational path from inputs to outputs.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with a=1, b=1, in_valid=1 -> all outputs 0, out_valid=0.
- Truth table, WIDTH=1: drive (a,b) = (0,0), (1,0), (0,1), (1,1) with in_valid=1 on consecutive cycles. Next cycle outputs (ya,yna,yo,yno,yx,yxn,ynota,ynotb) must be:
  - (0,0): 0,1,0,1,0,1,1,1
  - (1,0): 0,1,1,0,1,0,0,1
  - (0,1): 0,1,1,0,1,0,1,0
  - (1,1): 1,0,1,0,0,1,0,0
  - out_valid=1 each cycle.
- Hold: capture a=1, b=0, then drop in_valid for 3 cycles while toggling a/b -> outputs stay 0,1,1,0,1,0,0,1; out_valid=0.
- Bitwise, WIDTH=8: a=0xF0, b=0xCC -> ya=0xC0, yna=0x3F, yo=0xFC, yno=0x03, yx=0x3C, yxn=0xC3, ynota=0x0F, ynotb=0x33.
- Reset mid-stream: capture a=1, b=1, then assert rst with in_valid=1 -> next edge all outputs 0 and out_valid=0. Deassert rst and capture (0,0) -> 0,1,0,1,0,1,1,1.
- Random, 1000 cycles: random a, b, in_valid, occasional rst -> outputs match a 1-cycle-delayed model with hold and reset semantics.
